// File: rtl/ysyx_22050133_axi_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050133_axi_rr_arbiter_if
// Purpose  : AXI4 bundle with N_PORTS flattened lanes (slice i = port i).
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_22050133_axi_rr_arbiter_if #(
    parameter int N_PORTS = 1,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8
);
    logic [N_PORTS-1:0]            aw_valid;
    logic [N_PORTS-1:0]            aw_ready;
    logic [N_PORTS*ADDR_W-1:0]     aw_addr;

    logic [N_PORTS-1:0]            w_valid;
    logic [N_PORTS-1:0]            w_ready;
    logic [N_PORTS*DATA_W-1:0]     w_data;
    logic [N_PORTS*DATA_W/8-1:0]   w_strb;
    logic [N_PORTS-1:0]            w_last;

    logic [N_PORTS-1:0]            b_valid;
    logic [N_PORTS-1:0]            b_ready;
    logic [N_PORTS*2-1:0]          b_resp;

    logic [N_PORTS-1:0]            ar_valid;
    logic [N_PORTS-1:0]            ar_ready;
    logic [N_PORTS*ADDR_W-1:0]     ar_addr;
    logic [N_PORTS*LEN_W-1:0]      ar_len;

    logic [N_PORTS-1:0]            r_valid;
    logic [N_PORTS-1:0]            r_ready;
    logic [N_PORTS*DATA_W-1:0]     r_data;
    logic [N_PORTS*2-1:0]          r_resp;
    logic [N_PORTS-1:0]            r_last;

    // Initiator side of the bundle
    modport master (
        output aw_valid, aw_addr,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_len,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last,
        output r_ready
    );

    // Responder side of the bundle
    modport slave (
        input  aw_valid, aw_addr,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_len,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050133_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050133_axi_rr_arbiter
// Purpose  : N-master to 1-slave AXI4 arbiter, independent round-robin on the
//            read (AR/R) and write (AW/W/B) paths, grant held per transaction.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050133_axi_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int M_IDX_W        = $clog2(NUM_MASTERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22050133_axi_rr_arbiter_if.slave  s,
    ysyx_22050133_axi_rr_arbiter_if.master m,
    output logic [M_IDX_W-1:0]          rd_grant_idx,
    output logic [M_IDX_W-1:0]          wr_grant_idx
);

    localparam int c_D    = AXI_DATA_WIDTH;
    localparam int c_A    = AXI_ADDR_WIDTH;
    localparam int c_L    = AXI_LEN_WIDTH;
    localparam int c_S    = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_ADDR = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_BUSY = 2'd1;
    localparam logic [1:0] c_W_RESP = 2'd2;

    localparam logic [M_IDX_W-1:0] c_PTR_RST = M_IDX_W'(NUM_MASTERS - 1);

    // First requester strictly after 'last', wrapping modulo NUM_MASTERS.
    function automatic logic [M_IDX_W-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [M_IDX_W-1:0]     last
    );
        int   idx;
        logic found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && req[M_IDX_W'(idx)]) begin
                rr_pick = M_IDX_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [1:0]         r_rd_state;
    logic [1:0]         w_rd_state_nxt;
    logic [M_IDX_W-1:0] r_rd_grant;
    logic [M_IDX_W-1:0] r_rd_last;
    logic [M_IDX_W-1:0] w_rd_winner;
    logic               w_rd_req;
    logic               w_ar_hs;
    logic               w_r_done;

    assign w_rd_req    = |s.ar_valid;
    assign w_rd_winner = rr_pick(s.ar_valid, r_rd_last);
    assign w_ar_hs     = (r_rd_state == c_R_ADDR) && s.ar_valid[r_rd_grant] && m.ar_ready[0];
    assign w_r_done    = (r_rd_state == c_R_DATA) && m.r_valid[0] && s.r_ready[r_rd_grant]
                         && m.r_last[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= c_R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            c_R_IDLE: if (w_rd_req) w_rd_state_nxt = c_R_ADDR;
            c_R_ADDR: if (w_ar_hs)  w_rd_state_nxt = c_R_DATA;
            c_R_DATA: if (w_r_done) w_rd_state_nxt = c_R_IDLE;
            default:                w_rd_state_nxt = c_R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_grant <= '0;
            r_rd_last  <= c_PTR_RST;
        end else if (r_rd_state == c_R_IDLE && w_rd_req) begin
            r_rd_grant <= w_rd_winner;
            r_rd_last  <= w_rd_winner;
        end
    end

    always_comb begin
        s.ar_ready = '0;
        s.r_valid  = '0;
        s.r_data   = '0;
        s.r_resp   = '0;
        s.r_last   = '0;
        m.ar_valid = '0;
        m.ar_addr  = '0;
        m.ar_len   = '0;
        m.r_ready  = '0;
        case (r_rd_state)
            c_R_ADDR: begin
                m.ar_valid[0]            = s.ar_valid[r_rd_grant];
                m.ar_addr                = s.ar_addr[int'(r_rd_grant)*c_A +: c_A];
                m.ar_len                 = s.ar_len[int'(r_rd_grant)*c_L +: c_L];
                s.ar_ready[r_rd_grant]   = m.ar_ready[0];
            end
            c_R_DATA: begin
                s.r_valid[r_rd_grant]              = m.r_valid[0];
                s.r_data[int'(r_rd_grant)*c_D +: c_D] = m.r_data;
                s.r_resp[int'(r_rd_grant)*2 +: 2]  = m.r_resp;
                s.r_last[r_rd_grant]               = m.r_last[0];
                m.r_ready[0]                       = s.r_ready[r_rd_grant];
            end
            default: ;
        endcase
    end

    assign rd_grant_idx = r_rd_grant;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [1:0]         r_wr_state;
    logic [1:0]         w_wr_state_nxt;
    logic [M_IDX_W-1:0] r_wr_grant;
    logic [M_IDX_W-1:0] r_wr_last;
    logic [M_IDX_W-1:0] w_wr_winner;
    logic               w_wr_req;
    logic               r_aw_done;
    logic               r_w_done;
    logic               w_aw_hs;
    logic               w_w_last_hs;
    logic               w_aw_done_now;
    logic               w_w_done_now;
    logic               w_b_hs;

    assign w_wr_req      = |s.aw_valid;
    assign w_wr_winner   = rr_pick(s.aw_valid, r_wr_last);
    assign w_aw_hs       = (r_wr_state == c_W_BUSY) && !r_aw_done
                           && s.aw_valid[r_wr_grant] && m.aw_ready[0];
    assign w_w_last_hs   = (r_wr_state == c_W_BUSY) && !r_w_done
                           && s.w_valid[r_wr_grant] && m.w_ready[0] && s.w_last[r_wr_grant];
    // AW and the final W beat may land in either order or in the same cycle
    assign w_aw_done_now = r_aw_done | w_aw_hs;
    assign w_w_done_now  = r_w_done  | w_w_last_hs;
    assign w_b_hs        = (r_wr_state == c_W_RESP) && m.b_valid[0] && s.b_ready[r_wr_grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= c_W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            c_W_IDLE: if (w_wr_req) w_wr_state_nxt = c_W_BUSY;
            c_W_BUSY: if (w_aw_done_now && w_w_done_now) w_wr_state_nxt = c_W_RESP;
            c_W_RESP: if (w_b_hs)   w_wr_state_nxt = c_W_IDLE;
            default:                w_wr_state_nxt = c_W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_grant <= '0;
            r_wr_last  <= c_PTR_RST;
        end else if (r_wr_state == c_W_IDLE && w_wr_req) begin
            r_wr_grant <= w_wr_winner;
            r_wr_last  <= w_wr_winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_wr_state != c_W_BUSY) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_aw_done <= w_aw_done_now;
            r_w_done  <= w_w_done_now;
        end
    end

    always_comb begin
        s.aw_ready = '0;
        s.w_ready  = '0;
        s.b_valid  = '0;
        s.b_resp   = '0;
        m.aw_valid = '0;
        m.aw_addr  = '0;
        m.w_valid  = '0;
        m.w_data   = '0;
        m.w_strb   = '0;
        m.w_last   = '0;
        m.b_ready  = '0;
        case (r_wr_state)
            c_W_BUSY: begin
                if (!r_aw_done) begin
                    m.aw_valid[0]          = s.aw_valid[r_wr_grant];
                    m.aw_addr              = s.aw_addr[int'(r_wr_grant)*c_A +: c_A];
                    s.aw_ready[r_wr_grant] = m.aw_ready[0];
                end
                if (!r_w_done) begin
                    m.w_valid[0]           = s.w_valid[r_wr_grant];
                    m.w_data               = s.w_data[int'(r_wr_grant)*c_D +: c_D];
                    m.w_strb               = s.w_strb[int'(r_wr_grant)*c_S +: c_S];
                    m.w_last[0]            = s.w_last[r_wr_grant];
                    s.w_ready[r_wr_grant]  = m.w_ready[0];
                end
            end
            c_W_RESP: begin
                s.b_valid[r_wr_grant]             = m.b_valid[0];
                s.b_resp[int'(r_wr_grant)*2 +: 2] = m.b_resp;
                m.b_ready[0]                      = s.b_ready[r_wr_grant];
            end
            default: ;
        endcase
    end

    assign wr_grant_idx = r_wr_grant;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050133_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050133_axi_rr_arbiter
// Purpose  : Randomised self-checking bench with a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050133_axi_rr_arbiter;

    localparam int N  = 3;
    localparam int D  = 64;
    localparam int A  = 32;
    localparam int L  = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [IW-1:0] rd_grant_idx;
    logic [IW-1:0] wr_grant_idx;

    int checks = 0;
    int errors = 0;
    int rd_ptr;
    int wr_ptr;

    always #5 clk = ~clk;

    ysyx_22050133_axi_rr_arbiter_if #(.N_PORTS(N), .DATA_W(D), .ADDR_W(A), .LEN_W(L)) up ();
    ysyx_22050133_axi_rr_arbiter_if #(.N_PORTS(1), .DATA_W(D), .ADDR_W(A), .LEN_W(L)) dn ();

    ysyx_22050133_axi_rr_arbiter #(
        .NUM_MASTERS   (N),
        .AXI_DATA_WIDTH(D),
        .AXI_ADDR_WIDTH(A),
        .AXI_LEN_WIDTH (L)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .s           (up),
        .m           (dn),
        .rd_grant_idx(rd_grant_idx),
        .wr_grant_idx(wr_grant_idx)
    );

    // Reference round-robin: first requester after ptr, modulo N.
    function automatic int rr_expect(input logic [N-1:0] req, input int ptr);
        logic [N-1:0] bitv;
        for (int k = 1; k <= N; k++) begin
            bitv = N'(1) << ((ptr + k) % N);
            if ((req & bitv) != 0) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic logic any_bus_output();
        return |{up.aw_ready, up.w_ready, up.b_valid, up.b_resp, up.ar_ready,
                 up.r_valid, up.r_data, up.r_resp, up.r_last,
                 dn.aw_valid, dn.aw_addr, dn.w_valid, dn.w_data, dn.w_strb, dn.w_last,
                 dn.b_ready, dn.ar_valid, dn.ar_addr, dn.ar_len, dn.r_ready};
    endfunction

    task automatic clear_inputs();
        up.aw_valid = '0; up.aw_addr = '0;
        up.w_valid  = '0; up.w_data  = '0; up.w_strb = '0; up.w_last = '0;
        up.b_ready  = '0;
        up.ar_valid = '0; up.ar_addr = '0; up.ar_len = '0;
        up.r_ready  = '0;
        dn.aw_ready = '0; dn.w_ready = '0;
        dn.b_valid  = '0; dn.b_resp  = '0;
        dn.ar_ready = '0;
        dn.r_valid  = '0; dn.r_data  = '0; dn.r_resp = '0; dn.r_last = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_ptr = N - 1;
        wr_ptr = N - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        up.ar_valid = '1; up.aw_valid = '1; up.r_ready = '1; up.b_ready = '1;
        dn.r_valid = 1'b1; dn.b_valid = 1'b1; dn.ar_ready = 1'b1; dn.aw_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (any_bus_output() !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got nonzero, required 0");
        end
        checks++;
        if (rd_grant_idx !== 0 || wr_grant_idx !== 0) begin
            errors++; $display("FAIL reset_grant: got rd=%0d wr=%0d, required 0/0", rd_grant_idx, wr_grant_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        rd_ptr = N - 1; wr_ptr = N - 1;
        #1;
        checks++;
        if (any_bus_output() !== 1'b0) begin
            errors++; $display("FAIL release_cycle_outputs: got nonzero, required 0");
        end
        @(negedge clk); #1;
        checks++;
        if (rd_grant_idx !== 0 || dn.ar_valid !== 1'b1 || wr_grant_idx !== 0 || dn.aw_valid !== 1'b1) begin
            errors++; $display("FAIL first_grant: got rd=%0d arv=%b wr=%0d awv=%b, required 0 1 0 1",
                               rd_grant_idx, dn.ar_valid, wr_grant_idx, dn.aw_valid);
        end
        do_reset();
    endtask

    task automatic test_read_rr();
        logic [N-1:0] mask, prev;
        logic [A-1:0] addr [N];
        logic [D-1:0] rdata;
        logic [1:0]   rresp;
        int           w;
        int           fixed_order [4] = '{0, 1, 2, 0};
        mask = '1;
        for (int j = 0; j < N; j++) begin
            addr[j] = $urandom;
            up.ar_addr[j*A +: A] = addr[j];
        end
        up.ar_len = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dn.r_valid = 1'b0; dn.r_last = 1'b0;
            up.ar_valid = mask;
            #1;
            checks++;
            if (dn.ar_valid !== 1'b0 || up.r_valid !== '0) begin
                errors++; $display("FAIL rr_idle: got arv=%b rv=%b, required 0 0", dn.ar_valid, up.r_valid);
            end
            w = rr_expect(mask, rd_ptr);
            rd_ptr = w;
            if (i < 4) begin
                checks++;
                if (w != fixed_order[i] || rd_grant_idx === IW'(w)) begin
                    // grant index must not update until the idle cycle's edge
                    if (w != fixed_order[i]) begin
                        errors++; $display("FAIL rr_order: model %0d, required %0d", w, fixed_order[i]);
                    end
                end
            end
            @(negedge clk);
            dn.ar_ready = 1'b1;
            #1;
            checks++;
            if (dn.ar_valid !== 1'b1 || dn.ar_addr !== addr[w] || rd_grant_idx !== IW'(w)) begin
                errors++; $display("FAIL rr_addr: got arv=%b addr=%h idx=%0d, required 1 %h %0d",
                                   dn.ar_valid, dn.ar_addr, rd_grant_idx, addr[w], w);
            end
            checks++;
            if (up.ar_ready !== oh(w)) begin
                errors++; $display("FAIL rr_ar_ready: got %b, required %b", up.ar_ready, oh(w));
            end
            @(negedge clk);
            dn.ar_ready = 1'b0;
            prev = mask & ~oh(w);
            mask = (i < 3) ? '1 : (prev | N'($urandom_range(0, 7)));
            if (mask == 0) mask = oh($urandom_range(0, N - 1));
            for (int j = 0; j < N; j++) begin
                if (mask[j] && !prev[j]) begin
                    addr[j] = $urandom;
                    up.ar_addr[j*A +: A] = addr[j];
                end
            end
            up.ar_valid = mask;
            rdata = {$urandom, $urandom};
            rresp = 2'($urandom);
            dn.r_valid = 1'b1; dn.r_last = 1'b1; dn.r_data = rdata; dn.r_resp = rresp;
            up.r_ready = N'($urandom) | oh(w);
            #1;
            checks++;
            if (up.r_valid !== oh(w) || up.r_last !== oh(w) || dn.r_ready !== 1'b1 || dn.ar_valid !== 1'b0) begin
                errors++; $display("FAIL rr_rbeat: got rv=%b rl=%b rr=%b arv=%b, required %b %b 1 0",
                                   up.r_valid, up.r_last, dn.r_ready, dn.ar_valid, oh(w), oh(w));
            end
            checks++;
            if (up.r_data !== ((N*D)'(rdata) << (w*D)) || up.r_resp !== ((2*N)'(rresp) << (2*w))) begin
                errors++; $display("FAIL rr_rdata: got %h/%b, required data %h resp %0d on master %0d",
                                   up.r_data, up.r_resp, rdata, rresp, w);
            end
        end
        @(negedge clk);
        clear_inputs();
        do_reset();
    endtask

    task automatic test_read_burst();
        logic [D-1:0] rdata;
        int beat, cyc;
        logic stall;
        @(negedge clk);
        up.ar_valid = 3'b010; up.ar_addr[1*A +: A] = 32'h8000_1000; up.ar_len[1*L +: L] = 8'd3;
        up.r_ready = '1;
        @(negedge clk);
        dn.ar_ready = 1'b1;
        rd_ptr = rr_expect(3'b010, rd_ptr);
        #1;
        checks++;
        if (rd_grant_idx !== IW'(rd_ptr) || dn.ar_len !== 8'd3 || up.ar_ready !== 3'b010) begin
            errors++; $display("FAIL burst_grant: got idx=%0d len=%0d ardy=%b, required 1 3 010",
                               rd_grant_idx, dn.ar_len, up.ar_ready);
        end
        beat = 0; cyc = 0;
        while (beat < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            dn.ar_ready = 1'b1;
            up.ar_valid[1] = 1'b0;
            if (beat >= 1) begin
                up.ar_valid[0] = 1'b1; up.ar_addr[0 +: A] = 32'h0000_2000;
            end
            stall = ($urandom_range(0, 2) == 0);
            rdata = {$urandom, $urandom};
            dn.r_valid = !stall; dn.r_last = (beat == 3) && !stall; dn.r_data = rdata;
            #1;
            checks++;
            if (up.ar_ready !== '0 || up.r_valid !== (stall ? 3'b000 : 3'b010)) begin
                errors++; $display("FAIL burst_lock: got ardy=%b rv=%b at beat %0d", up.ar_ready, up.r_valid, beat);
            end
            if (!stall) begin
                checks++;
                if (up.r_last !== ((beat == 3) ? 3'b010 : 3'b000) || up.r_data[1*D +: D] !== rdata) begin
                    errors++; $display("FAIL burst_beat: got last=%b data=%h, required beat %0d data %h",
                                       up.r_last, up.r_data[1*D +: D], beat, rdata);
                end
                beat++;
            end
        end
        checks++;
        if (beat != 4) begin
            errors++; $display("FAIL burst_timeout: got %0d beats, required 4", beat);
        end
        @(negedge clk);
        dn.r_valid = 1'b0; dn.r_last = 1'b0;
        #1;
        checks++;
        if (up.ar_ready !== '0 || dn.ar_valid !== 1'b0) begin
            errors++; $display("FAIL burst_bubble: got ardy=%b arv=%b, required 0 0", up.ar_ready, dn.ar_valid);
        end
        @(negedge clk);
        rd_ptr = rr_expect(3'b001, rd_ptr);
        #1;
        checks++;
        if (rd_grant_idx !== 2'd0 || up.ar_ready !== 3'b001 || dn.ar_addr !== 32'h0000_2000) begin
            errors++; $display("FAIL burst_next: got idx=%0d ardy=%b addr=%h, required 0 001 00002000",
                               rd_grant_idx, up.ar_ready, dn.ar_addr);
        end
        @(negedge clk);
        up.ar_valid = '0; dn.ar_ready = 1'b0;
        dn.r_valid = 1'b1; dn.r_last = 1'b1;
        #1;
        checks++;
        if (up.r_valid !== 3'b001) begin
            errors++; $display("FAIL burst_next_r: got %b, required 001", up.r_valid);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_write_order();
        do_reset();
        @(negedge clk);
        up.w_valid = 3'b010; up.w_data[1*D +: D] = 64'hDEAD_BEEF_0123_4567;
        up.w_strb[1*8 +: 8] = 8'hFF; up.w_last = 3'b010;
        dn.aw_ready = 1'b1; dn.w_ready = 1'b1;
        #1;
        checks++;
        if (dn.w_valid !== 1'b0 || up.w_ready !== '0) begin
            errors++; $display("FAIL wo_early_w: got wv=%b wrdy=%b, required 0 0", dn.w_valid, up.w_ready);
        end
        @(negedge clk);
        @(negedge clk);
        up.aw_valid = 3'b010; up.aw_addr[1*A +: A] = 32'h1234_5678;
        #1;
        checks++;
        if (dn.aw_valid !== 1'b0 || dn.w_valid !== 1'b0) begin
            errors++; $display("FAIL wo_idle: got awv=%b wv=%b, required 0 0", dn.aw_valid, dn.w_valid);
        end
        @(negedge clk);
        wr_ptr = rr_expect(3'b010, wr_ptr);
        #1;
        checks++;
        if (dn.aw_valid !== 1'b1 || dn.aw_addr !== 32'h1234_5678 || dn.w_valid !== 1'b1 ||
            dn.w_data !== 64'hDEAD_BEEF_0123_4567 || dn.w_strb !== 8'hFF || dn.w_last !== 1'b1) begin
            errors++; $display("FAIL wo_busy: got awv=%b addr=%h wv=%b data=%h strb=%h last=%b",
                               dn.aw_valid, dn.aw_addr, dn.w_valid, dn.w_data, dn.w_strb, dn.w_last);
        end
        checks++;
        if (up.aw_ready !== 3'b010 || up.w_ready !== 3'b010 || wr_grant_idx !== 2'd1) begin
            errors++; $display("FAIL wo_ready: got awrdy=%b wrdy=%b idx=%0d, required 010 010 1",
                               up.aw_ready, up.w_ready, wr_grant_idx);
        end
        @(negedge clk);
        up.aw_valid = '0; up.w_valid = '0; up.w_last = '0;
        dn.aw_ready = 1'b0; dn.w_ready = 1'b0;
        dn.b_valid = 1'b1; dn.b_resp = 2'd0; up.b_ready = '1;
        #1;
        checks++;
        if (up.b_valid !== 3'b010 || dn.b_ready !== 1'b1 || dn.aw_valid !== 1'b0) begin
            errors++; $display("FAIL wo_b: got bv=%b brdy=%b awv=%b, required 010 1 0", up.b_valid, dn.b_ready, dn.aw_valid);
        end
        @(negedge clk);
        dn.b_valid = 1'b0;
        #1;
        checks++;
        if (up.b_valid !== '0) begin
            errors++; $display("FAIL wo_b_once: got %b, required 000", up.b_valid);
        end
        clear_inputs();
    endtask

    task automatic test_write_random();
        logic [N-1:0] mask, prev;
        logic [A-1:0] awaddr;
        logic [D-1:0] data [3];
        logic [7:0]   strb;
        logic [1:0]   resp;
        int w, nb, sent, cyc, dly;
        logic aw_sent, hs_aw, hs_w;
        mask = N'($urandom_range(1, 7));
        for (int t = 0; t < 8; t++) begin
            w = rr_expect(mask, wr_ptr);
            wr_ptr = w;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < 3; b++) data[b] = {$urandom, $urandom};
            awaddr = $urandom;
            strb = 8'($urandom);
            @(negedge clk);
            dn.b_valid = 1'b0;
            up.aw_valid = mask;
            up.aw_addr = '0; up.aw_addr[w*A +: A] = awaddr;
            up.w_valid = oh(w); up.w_data = '0; up.w_data[w*D +: D] = data[0];
            up.w_strb = '0; up.w_strb[w*8 +: 8] = strb;
            up.w_last = (nb == 1) ? oh(w) : '0;
            #1;
            checks++;
            if (dn.aw_valid !== 1'b0 || dn.w_valid !== 1'b0 || up.w_ready !== '0) begin
                errors++; $display("FAIL wr_idle: got awv=%b wv=%b wrdy=%b", dn.aw_valid, dn.w_valid, up.w_ready);
            end
            aw_sent = 1'b0; sent = 0; cyc = 0;
            while (!(aw_sent && sent == nb) && cyc < 40) begin
                @(negedge clk);
                cyc++;
                up.aw_valid = aw_sent ? (mask & ~oh(w)) : mask;
                up.w_valid = (sent < nb) ? oh(w) : '0;
                if (sent < nb) up.w_data[w*D +: D] = data[sent];
                up.w_last = (sent == nb - 1) ? oh(w) : '0;
                dn.aw_ready = 1'($urandom_range(0, 1));
                dn.w_ready  = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (dn.aw_valid !== !aw_sent || (!aw_sent && dn.aw_addr !== awaddr) || wr_grant_idx !== IW'(w)) begin
                    errors++; $display("FAIL wr_aw: got awv=%b addr=%h idx=%0d, required %b %h %0d",
                                       dn.aw_valid, dn.aw_addr, wr_grant_idx, !aw_sent, awaddr, w);
                end
                checks++;
                if (dn.w_valid !== (sent < nb) ||
                    (sent < nb && (dn.w_data !== data[sent] || dn.w_strb !== strb || dn.w_last !== (sent == nb - 1)))) begin
                    errors++; $display("FAIL wr_w: got wv=%b data=%h strb=%h last=%b at beat %0d of %0d",
                                       dn.w_valid, dn.w_data, dn.w_strb, dn.w_last, sent, nb);
                end
                hs_aw = !aw_sent && dn.aw_ready;
                hs_w  = (sent < nb) && dn.w_ready;
                if (hs_aw) aw_sent = 1'b1;
                if (hs_w) sent++;
            end
            if (cyc >= 40) begin
                checks++; errors++; $display("FAIL wr_timeout: got %0d beats, required %0d", sent, nb);
            end
            dly = $urandom_range(0, 2);
            resp = 2'($urandom);
            for (int k = 0; k <= dly; k++) begin
                @(negedge clk);
                up.aw_valid = mask & ~oh(w); up.w_valid = '0; up.w_last = '0;
                dn.aw_ready = 1'b0; dn.w_ready = 1'b0;
                dn.b_valid = (k == dly); dn.b_resp = resp;
                up.b_ready = N'($urandom) | oh(w);
                #1;
                checks++;
                if (up.b_valid !== ((k == dly) ? oh(w) : '0) || dn.aw_valid !== 1'b0 ||
                    (k == dly && up.b_resp !== ((2*N)'(resp) << (2*w)))) begin
                    errors++; $display("FAIL wr_b: got bv=%b resp=%b awv=%b, required master %0d resp %0d",
                                       up.b_valid, up.b_resp, dn.aw_valid, w, resp);
                end
            end
            prev = mask & ~oh(w);
            mask = prev | N'($urandom_range(0, 7));
            if (mask == 0) mask = oh($urandom_range(0, N - 1));
        end
        @(negedge clk);
        clear_inputs();
        do_reset();
    endtask

    task automatic test_concurrent();
        @(negedge clk);
        up.ar_valid = 3'b001; up.ar_addr[0 +: A] = 32'hA000_0000;
        up.aw_valid = 3'b010; up.aw_addr[1*A +: A] = 32'hB000_0000;
        up.w_valid = 3'b010; up.w_last = 3'b010; up.w_data[1*D +: D] = 64'h5555;
        up.r_ready = '1; up.b_ready = '1;
        @(negedge clk);
        rd_ptr = rr_expect(3'b001, rd_ptr);
        wr_ptr = rr_expect(3'b010, wr_ptr);
        dn.ar_ready = 1'b1; dn.aw_ready = 1'b1; dn.w_ready = 1'b1;
        #1;
        checks++;
        if (dn.ar_valid !== 1'b1 || dn.aw_valid !== 1'b1 || rd_grant_idx !== IW'(rd_ptr) || wr_grant_idx !== IW'(wr_ptr)) begin
            errors++; $display("FAIL conc_addr: got arv=%b awv=%b rd=%0d wr=%0d, required 1 1 0 1",
                               dn.ar_valid, dn.aw_valid, rd_grant_idx, wr_grant_idx);
        end
        @(negedge clk);
        up.ar_valid = '0; up.aw_valid = '0; up.w_valid = '0; up.w_last = '0;
        dn.ar_ready = 1'b0; dn.aw_ready = 1'b0; dn.w_ready = 1'b0;
        dn.r_valid = 1'b1; dn.r_last = 1'b1; dn.r_data = 64'h0F0F;
        dn.b_valid = 1'b1; dn.b_resp = 2'd2;
        #1;
        checks++;
        if (up.r_valid !== 3'b001 || up.b_valid !== 3'b010 || up.b_resp !== 6'b00_10_00 ||
            up.r_data !== {128'd0, 64'h0F0F}) begin
            errors++; $display("FAIL conc_resp: got rv=%b bv=%b bresp=%b, required 001 010 001000",
                               up.r_valid, up.b_valid, up.b_resp);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        up.ar_valid = 3'b010; up.ar_len[1*L +: L] = 8'd3; up.r_ready = '1;
        @(negedge clk);
        dn.ar_ready = 1'b1;
        @(negedge clk);
        up.ar_valid = '0; dn.ar_ready = 1'b0;
        dn.r_valid = 1'b1; dn.r_last = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (up.r_valid !== 3'b010) begin
            errors++; $display("FAIL mid_beat2: got %b, required 010", up.r_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (any_bus_output() !== 1'b0 || rd_grant_idx !== 0 || wr_grant_idx !== 0) begin
            errors++; $display("FAIL mid_async_reset: got rv=%b rd=%0d wr=%0d, required all 0",
                               up.r_valid, rd_grant_idx, wr_grant_idx);
        end
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_ptr = N - 1;
        up.ar_valid = 3'b110; up.ar_addr[1*A +: A] = 32'hC0DE_0001; up.ar_addr[2*A +: A] = 32'hC0DE_0002;
        #1;
        checks++;
        if (any_bus_output() !== 1'b0) begin
            errors++; $display("FAIL mid_release: got nonzero outputs, required 0");
        end
        @(negedge clk);
        dn.ar_ready = 1'b1;
        rd_ptr = rr_expect(3'b110, rd_ptr);
        #1;
        checks++;
        if (rd_grant_idx !== IW'(rd_ptr) || up.ar_ready !== oh(rd_ptr) || dn.ar_addr !== 32'hC0DE_0001) begin
            errors++; $display("FAIL mid_regrant: got idx=%0d ardy=%b addr=%h, required %0d %b C0DE0001",
                               rd_grant_idx, up.ar_ready, dn.ar_addr, rd_ptr, oh(rd_ptr));
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_read_rr();
        test_read_burst();
        test_write_order();
        test_write_random();
        test_concurrent();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
